snap_capture_ctrl: RTL and testbench
====================================

// Module: snap_capture_ctrl
// PURPOSE
//  Write-side controller for the snapshot capture BRAM. Takes the 128-bit ADC sample word stream,
//  waits for arm and trigger, then writes DEPTH words into port A of the snap buffer.
//  Reports done and the word count to the processor side through a 32-bit status word.
// PARAMETERS
//  AW        12    BRAM port-A address width; buffer depth is 2**AW words
//  DW        128   Sample word width; equals the BRAM port-A data width
//  POST_LEN  2048  Circular mode only: words written after the trigger (1..2**AW)
// PORTS
//  clk           in   1    capture clock (ADC sample clock domain)
//  rst           in   1    asynchronous, active-high reset
//  din           in   DW   sample word
//  din_vld       in   1    sample qualifier
//  trig          in   1    external trigger, level, sampled each cycle
//  ctrl          in   32   [0] arm (rising edge); [1] trig_sel (0 = immediate, 1 = ext);
//                           [2] vld_sel (0 = every cycle, 1 = din_vld); [3] circ (circular mode)
//  bram_addr     out  AW   port-A address
//  bram_wr_data  out  DW   port-A write data
//  bram_we       out  1    port-A write enable
//  status        out  32   [31] done; [30] armed/busy; [AW+16:16] trig_addr; [AW:0] word count
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, counters 0, arm-edge register 0.
//  arm_p = ctrl[0] & ~ctrl_q[0], where ctrl_q is registered.
//  wr = (vld_sel ? din_vld : 1).
//  hit = (trig_sel ? trig : 1).
//  States:
//   IDLE:    arm_p -> clear count and done, go to ARMED. done holds its value across IDLE.
//   ARMED:   hit && wr -> go to CAPTURE; the triggering word is written as address 0.
//   CAPTURE: each wr cycle writes at addr = count, then count++.
//            When count reaches 2**AW (count width is AW+1 bits): set done, go to IDLE.
//            Words with wr = 0 are skipped; the address does not advance.
//  Write latency: din, bram_addr and bram_we are registered, so a write lands 1 clk after
//   the accepted din cycle. bram_we is high for exactly one cycle per accepted word.
//  Words written per arm: exactly 2**AW. There is no address wrap in linear mode.
//  A trigger in IDLE is ignored.
//  arm_p while ARMED or CAPTURE restarts capture: count = 0, done = 0, state ARMED.
//   Words already written are not erased.
//  rst mid-capture: immediately back to IDLE, bram_we = 0, done = 0.
//  status[30] = (state != IDLE). status[AW:0] = count, which reads 2**AW when done.
//  ctrl bits [3:1] are sampled on every cycle; software sets them before asserting arm.
// CONFIGURATION
//  SNAP_CIRC_EN defined: ctrl[3] = 1 selects circular pre-trigger capture.
//   - After arm_p, writes start immediately; the address wraps modulo 2**AW.
//   - On the first cycle with hit && wr, the current address is latched into trig_addr
//     and a post counter starts.
//   - Exactly POST_LEN more words are written after that trigger word, then done is set
//     and state returns to IDLE.
//   - count saturates at 2**AW, which marks a full pre-trigger history.
//   - The trigger is ignored until at least one word has been written after arm.
//  SNAP_CIRC_EN undefined: ctrl[3] is ignored, circular logic is absent, status trig_addr
//   field reads 0, and POST_LEN is unused.
// TESTING
//  1 rst high mid-run; check: all outputs 0 while asserted. Then arm, ctrl = 0x1 ->
//    4096 consecutive we pulses, addr 0..4095, done = 1 on the cycle after the last, count = 4096.
//  2 ctrl = 0x3 (ext trig) with trig low for 100 cycles -> no writes, status[30] = 1.
//    Pulse trig on din = 0xA5.. -> addr 0 is written with 0xA5.. one cycle later.
//  3 ctrl = 0x5 with din_vld toggling 1,0,1,0 -> we follows din_vld delayed by 1.
//    Addresses are contiguous; done arrives after 4096 valid words, not after 4096 cycles.
//  4 Re-arm at count = 1000 -> count returns to 0, done = 0, next write at addr 0.
//    Trigger in IDLE (no arm) -> no writes.
//  5 SNAP_CIRC_EN, ctrl = 0xB, POST_LEN = 2048: trig after 5000 words ->
//    trig_addr = 5000 mod 4096 = 904; 2048 further writes; last addr = 904+2048 = 2952; done = 1.
//  6 SNAP_CIRC_EN undefined, ctrl = 0xB -> behaves exactly as linear ext-trigger capture
//    (same as scenario 2).

Source files
------------

// File: rtl/snap_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : snap_capture_ctrl
// Description : Write-side controller for the snapshot capture BRAM. Accepts
//               the ADC sample word stream, waits for arm and trigger, then
//               writes 2**AW words into port A of the snap buffer and reports
//               done / trigger address / word count through a status word.
// Ports       : clk, rst          capture clock, async active-high reset
//               din, din_vld      sample word and its qualifier
//               trig              external level trigger
//               ctrl[3:0]         {circ, vld_sel, trig_sel, arm}
//               bram_addr/_wr_data/_we   registered port-A write interface
//               status            {done, busy, trig_addr, word count}
// Config      : SNAP_CIRC_EN      enables circular pre-trigger capture
//                                 (ctrl[3]); absent otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module snap_capture_ctrl #(
    parameter int AW       = 12,
    parameter int DW       = 128,
    parameter int POST_LEN = 2048
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    input  logic          trig,
    input  logic [31:0]   ctrl,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_wr_data,
    output logic          bram_we,
    output logic [31:0]   status
);

    localparam logic [AW:0]   C_FULL     = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   C_LAST     = C_FULL - (AW+1)'(1);
    localparam logic [AW:0]   C_CNT_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_CIRC    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            arm_prev_q, arm_prev_d;
    logic [AW:0]     count_q, count_d;
    logic            done_q, done_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;

    logic            arm_p;
    logic            wr;
    logic            hit;
    logic [AW-1:0]   trig_addr_w;

    assign arm_p = ctrl[0] & ~arm_prev_q;
    assign wr    = ctrl[2] ? din_vld : 1'b1;
    assign hit   = ctrl[1] ? trig    : 1'b1;

`ifdef SNAP_CIRC_EN
    localparam logic [AW-1:0] C_PTR_ONE   = AW'(1);
    localparam logic [AW:0]   C_POST_LAST = (AW+1)'(POST_LEN - 1);

    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   trig_addr_q, trig_addr_d;
    logic [AW:0]     post_cnt_q, post_cnt_d;
    logic            post_act_q, post_act_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            trig_addr_q <= '0;
            post_cnt_q  <= '0;
            post_act_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            trig_addr_q <= trig_addr_d;
            post_cnt_q  <= post_cnt_d;
            post_act_q  <= post_act_d;
        end
    end

    assign trig_addr_w = trig_addr_q;

    logic unused_ctrl;
    assign unused_ctrl = ^ctrl[31:4];
`else
    assign trig_addr_w = '0;

    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl[31:3], (POST_LEN == 0)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            arm_prev_q <= 1'b0;
            count_q    <= '0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            arm_prev_q <= arm_prev_d;
            count_q    <= count_d;
            done_q     <= done_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        arm_prev_d = ctrl[0];
        count_d    = count_q;
        done_d     = done_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef SNAP_CIRC_EN
        ptr_d       = ptr_q;
        trig_addr_d = trig_addr_q;
        post_cnt_d  = post_cnt_q;
        post_act_d  = post_act_q;
`endif
        // An arm edge restarts from any state; already written words stay.
        if (arm_p) begin
            count_d = '0;
            done_d  = 1'b0;
            state_d = ST_ARMED;
`ifdef SNAP_CIRC_EN
            if (ctrl[3]) begin
                state_d     = ST_CIRC;
                ptr_d       = '0;
                trig_addr_d = '0;
                post_cnt_d  = '0;
                post_act_d  = 1'b0;
            end
`endif
        end else begin
            case (state_q)
                ST_ARMED: begin
                    // The triggering word itself is the first one stored.
                    if (hit && wr) begin
                        we_d    = 1'b1;
                        addr_d  = '0;
                        data_d  = din;
                        count_d = C_CNT_ONE;
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (wr) begin
                        we_d    = 1'b1;
                        addr_d  = count_q[AW-1:0];
                        data_d  = din;
                        count_d = count_q + C_CNT_ONE;
                        if (count_q == C_LAST) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
`ifdef SNAP_CIRC_EN
                ST_CIRC: begin
                    if (wr) begin
                        we_d   = 1'b1;
                        addr_d = ptr_q;
                        data_d = din;
                        ptr_d  = ptr_q + C_PTR_ONE;
                        // count saturating at full depth flags a complete history
                        if (count_q != C_FULL) begin
                            count_d = count_q + C_CNT_ONE;
                        end
                        if (post_act_q) begin
                            post_cnt_d = post_cnt_q + C_CNT_ONE;
                            if (post_cnt_q == C_POST_LAST) begin
                                done_d     = 1'b1;
                                post_act_d = 1'b0;
                                state_d    = ST_IDLE;
                            end
                        end else if (hit && (count_q != '0)) begin
                            trig_addr_d = ptr_q;
                            post_act_d  = 1'b1;
                            post_cnt_d  = '0;
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign bram_we      = we_q;
    assign bram_addr    = addr_q;
    assign bram_wr_data = data_q;

    always_comb begin
        status            = '0;
        status[31]        = done_q;
        status[30]        = (state_q != ST_IDLE);
        status[AW+16:16]  = {1'b0, trig_addr_w};
        status[AW:0]      = count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_snap_capture_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_snap_capture_ctrl
// Description : Self-checking bench for snap_capture_ctrl. A reference model
//               pushes expected writes to a scoreboard queue as stimulus is
//               accepted; a monitor pops and compares on each bram_we pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snap_capture_ctrl;

    localparam int AW       = 12;
    localparam int DW       = 128;
    localparam int POST_LEN = 2048;
    localparam int DEPTH    = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_vld;
    logic          trig;
    logic [31:0]   ctrl;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wr_data;
    logic          bram_we;
    logic [31:0]   status;

    always #5 clk = ~clk;

    snap_capture_ctrl #(.AW(AW), .DW(DW), .POST_LEN(POST_LEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_vld      (din_vld),
        .trig         (trig),
        .ctrl         (ctrl),
        .bram_addr    (bram_addr),
        .bram_wr_data (bram_wr_data),
        .bram_we      (bram_we),
        .status       (status)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t sb_q[$];

    typedef enum int {M_IDLE, M_ARMED, M_CAP, M_CIRC} mstate_t;
    mstate_t m_state;
    logic    m_arm_prev, m_done, m_pact, m_arm_p, m_wr, m_hit;
    int      m_count, m_ptr, m_trig_addr, m_post;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = M_IDLE; m_arm_prev = 0; m_done = 0; m_pact = 0;
            m_count = 0; m_ptr = 0; m_trig_addr = 0; m_post = 0;
        end else begin
            m_arm_p    = ctrl[0] && !m_arm_prev;
            m_wr       = ctrl[2] ? din_vld : 1'b1;
            m_hit      = ctrl[1] ? trig : 1'b1;
            m_arm_prev = ctrl[0];
            if (m_arm_p) begin
                m_count = 0; m_done = 0; m_state = M_ARMED;
`ifdef SNAP_CIRC_EN
                if (ctrl[3]) begin
                    m_state = M_CIRC; m_ptr = 0; m_post = 0; m_pact = 0; m_trig_addr = 0;
                end
`endif
            end else begin
                case (m_state)
                    M_ARMED: if (m_hit && m_wr) begin
                        sb_q.push_back({AW'(0), din});
                        m_count = 1; m_state = M_CAP;
                    end
                    M_CAP: if (m_wr) begin
                        sb_q.push_back({AW'(m_count), din});
                        m_count++;
                        if (m_count == DEPTH) begin m_done = 1; m_state = M_IDLE; end
                    end
                    M_CIRC: if (m_wr) begin
                        sb_q.push_back({AW'(m_ptr), din});
                        if (m_pact) begin
                            m_post++;
                            if (m_post == POST_LEN) begin m_done = 1; m_pact = 0; m_state = M_IDLE; end
                        end else if (m_hit && m_count != 0) begin
                            m_trig_addr = m_ptr; m_pact = 1; m_post = 0;
                        end
                        m_ptr = (m_ptr + 1) % DEPTH;
                        if (m_count < DEPTH) m_count++;
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[31]       = m_done;
        s[30]       = (m_state != M_IDLE);
        s[AW+16:16] = m_trig_addr[AW:0];
        s[AW:0]     = m_count[AW:0];
        return s;
    endfunction

    // ---------------- monitor ----------------
    int            we_cnt = 0;
    logic [AW-1:0] last_addr = '0;
    wr_t           mon_exp;

    always @(negedge clk) begin
        if (bram_we) begin
            we_cnt++;
            last_addr = bram_addr;
            if (sb_q.size() == 0) begin
                check_value("unexpected_we", 1, 0);
            end else begin
                mon_exp = sb_q.pop_front();
                check_value("wr_addr", bram_addr, mon_exp.addr);
                check_value("wr_data", bram_wr_data, mon_exp.data);
            end
        end
        if (!rst) check_value("status", status, model_status());
    end

    // ---------------- stimulus helpers ----------------
    bit toggle_vld = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        din = {$urandom(), $urandom(), $urandom(), $urandom()};
        din_vld = toggle_vld ? ~din_vld : 1'b1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int max_cyc, output int cyc);
        cyc = 0;
        while (!status[31] && cyc < max_cyc) begin
            tick();
            sample();
            cyc++;
        end
        check_value(tag, status[31], 1);
    endtask

    task automatic arm(input logic [31:0] value);
        ctrl = 32'h0;
        tick();
        ctrl = value;
        tick();
        sample();
        check_value("arm_clears_done", status[31], 0);
    endtask

    localparam logic [DW-1:0] C_A5 = {16{8'hA5}};

    int w0, cyc, n;

    initial begin
        rst = 1'b1; ctrl = 32'h0; din = '0; din_vld = 1'b1; trig = 1'b0;
        repeat (3) @(posedge clk);
        sample();
        check_value("rst_we", bram_we, 0);
        check_value("rst_addr", bram_addr, 0);
        check_value("rst_data", bram_wr_data, 0);
        check_value("rst_status", status, 0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: reset mid-capture, then full linear capture
        ctrl = 32'h1;
        repeat (50) tick();
        rst = 1'b1; ctrl = 32'h0;
        sb_q.delete();
        sample();
        check_value("midrst_we", bram_we, 0);
        check_value("midrst_addr", bram_addr, 0);
        check_value("midrst_data", bram_wr_data, 0);
        check_value("midrst_status", status, 0);
        tick(); tick();
        rst = 1'b0;
        w0 = we_cnt;
        arm(32'h1);
        wait_done("s1_done", 10000, cyc);
        check_value("s1_we_count", we_cnt - w0, DEPTH);
        check_value("s1_last_addr", last_addr, DEPTH - 1);
        check_value("s1_count", status[AW:0], DEPTH);
        check_value("s1_not_busy", status[30], 0);

        // 2: external trigger held low, then a single pulse
        arm(32'h3);
        w0 = we_cnt;
        repeat (100) tick();
        sample();
        check_value("s2_no_writes", we_cnt - w0, 0);
        check_value("s2_busy", status[30], 1);
        din = C_A5; trig = 1'b1;
        tick();
        trig = 1'b0;
        sample();
        check_value("s2_trig_we", bram_we, 1);
        check_value("s2_trig_addr", bram_addr, 0);
        check_value("s2_trig_data", bram_wr_data, C_A5);
        wait_done("s2_done", 10000, cyc);
        check_value("s2_we_count", we_cnt - w0, DEPTH);

        // 3: valid-qualified capture with din_vld toggling
        toggle_vld = 1;
        w0 = we_cnt;
        arm(32'h5);
        wait_done("s3_done", 12000, cyc);
        check_value("s3_we_count", we_cnt - w0, DEPTH);
        check_value("s3_slow", cyc >= 8000, 1);
        toggle_vld = 0;

        // 4: re-arm at count 1000, then trigger while idle
        arm(32'h1);
        n = 0;
        while (status[AW:0] != 1000 && n < 3000) begin
            tick(); sample(); n++;
        end
        check_value("s4_reach_1000", status[AW:0], 1000);
        ctrl = 32'h0;
        tick();
        ctrl = 32'h1;
        tick();
        sample();
        check_value("s4_rearm_count", status[AW:0], 0);
        check_value("s4_rearm_done", status[31], 0);
        check_value("s4_rearm_busy", status[30], 1);
        tick();
        sample();
        check_value("s4_first_we", bram_we, 1);
        check_value("s4_first_addr", bram_addr, 0);
        wait_done("s4_done", 10000, cyc);
        ctrl = 32'h2; trig = 1'b1;
        w0 = we_cnt;
        repeat (50) tick();
        sample();
        check_value("s4_idle_trig_no_writes", we_cnt - w0, 0);
        check_value("s4_idle_not_busy", status[30], 0);
        check_value("s4_idle_done_held", status[31], 1);
        trig = 1'b0;

`ifdef SNAP_CIRC_EN
        // 5: circular pre-trigger capture
        w0 = we_cnt;
        arm(32'hB);
        repeat (4999) tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        wait_done("s5_done", 5000, cyc);
        check_value("s5_trig_addr", status[AW+16:16], 904);
        check_value("s5_last_addr", last_addr, 2952);
        check_value("s5_count", status[AW:0], DEPTH);
        check_value("s5_we_count", we_cnt - w0, 5000 + 1 + POST_LEN);
`else
        // 6: circular bit ignored -> plain external-trigger capture
        arm(32'hB);
        w0 = we_cnt;
        repeat (100) tick();
        sample();
        check_value("s6_no_writes", we_cnt - w0, 0);
        check_value("s6_busy", status[30], 1);
        din = C_A5; trig = 1'b1;
        tick();
        trig = 1'b0;
        sample();
        check_value("s6_trig_we", bram_we, 1);
        check_value("s6_trig_addr", bram_addr, 0);
        check_value("s6_trig_data", bram_wr_data, C_A5);
        wait_done("s6_done", 10000, cyc);
        check_value("s6_we_count", we_cnt - w0, DEPTH);
        check_value("s6_trig_field", status[AW+16:16], 0);
`endif

        repeat (3) tick();
        sample();
        check_value("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
